oam_dma_ctrl: RTL
=================

Name: oam_dma_ctrl

Overview:
- Sequencer for OAM DMA in the DMG model: a write to the FF46 register copies LEN bytes from {base,8'h00} into OAM (FE00–FE9F), one byte per M-cycle.
- Pipelined source read and OAM write; arbitrates the external bus between CPU and DMA.
- Sits between the CPU bus decoder, the source memory mux and the OAM write port. All state advances on mcyc_en-qualified clock edges.

Parameters:
- LEN, 160, bytes per transfer (1..256)
- START_DELAY, 1, M-cycles between the register write and the first source read (0..3)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mcyc_en  in  1  one-clk pulse per M-cycle; qualifies every state update
- reg_wr  in  1  write strobe for FF46, sampled only when mcyc_en=1
- reg_wdata  in  8  source page written to FF46
- reg_rdata  out  8  FF46 readback, equal to base
- cpu_addr  in  16  current CPU bus address
- cpu_gnt  out  1  CPU access permitted this cycle (combinational)
- src_rd  out  1  DMA source read strobe
- src_addr  out  16  DMA source address
- src_data  in  8  source read data, valid at the mcyc_en edge
- oam_wr  out  1  OAM write strobe (level; OAM captures on the mcyc_en edge)
- oam_addr  out  8  OAM byte index
- oam_wdata  out  8  OAM write data
- dma_active  out  1  DMA owns the bus
- done  out  1  one-clk pulse when the last OAM write retires

Behaviour:
- Reset (async): state=IDLE, base=8'hFF, idx=0, dcnt=0, wr_pend=0, restart=0, done=0. All strobes and dma_active are 0, cpu_gnt=1.
- States: IDLE, DELAY, XFER. Registers updated only on a clk edge with mcyc_en=1, except done.
- reg_wr in any state:
  - base<=reg_wdata; idx<=0.
  - If START_DELAY=0, go to XFER; otherwise go to DELAY with dcnt<=START_DELAY.
  - restart<=1 if the current state is XFER or restart is already 1; else restart<=0.
- DELAY: dcnt decrements. When dcnt==1, go to XFER with idx=0.
- XFER:
  - src_rd=1. src_addr={mbase,idx}, where mbase = base-8'h20 if base>=8'hE0, else base.
  - On each edge: wr_pend<=1, wr_idx<=idx, wr_data<=src_data, idx<=idx+1.
  - On the edge where idx==LEN-1: go to IDLE and clear restart.
- Write stage:
  - oam_wr=wr_pend, oam_addr=wr_idx, oam_wdata=wr_data.
  - On each edge, wr_pend clears unless a new byte is loaded the same edge.
- done: asserted for exactly one clk after the edge where wr_pend goes 1->0 while state==IDLE.
- Latency: with START_DELAY=1, a write in M-cycle n gives:
  - first read in M n+2
  - last read in M n+LEN+1
  - last OAM write in M n+LEN+2
- dma_active = (state==XFER) | wr_pend | restart. The first DELAY of a fresh transfer does not block the CPU.
- cpu_gnt = !dma_active, or cpu_addr within FF80–FFFE (HRAM always granted).
- Restart mid-transfer: the pipelined write of the previous byte still retires; the source sequence restarts at idx 0 from the new base. The bus stays blocked throughout.
- reg_wr on the same edge as the final XFER byte: restart wins and the final byte's OAM write still retires. done fires only at the end of the restarted transfer.
- Reset mid-transfer: aborts immediately, no further OAM writes, done not asserted.
- reg_rdata = base in all states.

Optional Feature:
- OAM_DMA_BUS_LOCK_EN
- Defined: while dma_active, the CPU is blocked at every address except FF80–FFFE (behaviour above).
- Undefined: while dma_active, the CPU is blocked only for FE00–FEFF (OAM) and for any address in the same 8 KiB region as src_addr[15:13]. All other addresses are granted.

Test Plan:
- Reset, then reg_wr=1, reg_wdata=8'hC1 in M0 with START_DELAY=1:
  - M2 reads C100, M161 reads C19F.
  - OAM writes FE00..FE9F carry src data in M3..M162.
  - done pulses once after M162; dma_active=1 over M2..M162.
- reg_wdata=8'hE3: src_addr walks C300..C39F (echo mirror); reg_rdata=8'hE3.
- During XFER, cpu_addr=FF90 -> cpu_gnt=1; cpu_addr=C000 -> cpu_gnt=0. After done, cpu_addr=C000 -> cpu_gnt=1.
- Restart with 8'hD0 at idx=50:
  - OAM write idx 49 still occurs.
  - dma_active stays 1, next read is D000, 160 more reads follow, exactly one done.
- Assert reset at idx=80: all outputs return to reset values within the same clk, no further oam_wr, no done.
- Without OAM_DMA_BUS_LOCK_EN, source C1xx: cpu_addr=8000 -> cpu_gnt=1, cpu_addr=C800 -> 0, cpu_addr=FE10 -> 0.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: a write to FF46 copies LEN bytes from {base,8'h00} into OAM, one per M-cycle.
// Build option OAM_DMA_BUS_LOCK_EN: block every CPU address except HRAM while DMA is active.
module oam_dma_ctrl #(
   parameter int unsigned LEN         = 160,
   parameter int unsigned START_DELAY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mcyc_en,
   input  logic        reg_wr,
   input  logic [7:0]  reg_wdata,
   output logic [7:0]  reg_rdata,
   input  logic [15:0] cpu_addr,
   output logic        cpu_gnt,
   output logic        src_rd,
   output logic [15:0] src_addr,
   input  logic [7:0]  src_data,
   output logic        oam_wr,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_wdata,
   output logic        dma_active,
   output logic        done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DELAY = 2'd1;
   localparam logic [1:0] XFER  = 2'd2;

   localparam logic [7:0] LAST_IDX = 8'(LEN - 1);
   localparam logic [1:0] DLY_INIT = 2'(START_DELAY);

   logic [1:0] state;
   logic [7:0] base;
   logic [7:0] idx;
   logic [1:0] dcnt;
   logic       wr_pend;
   logic [7:0] wr_idx;
   logic [7:0] wr_data;
   logic       restart;
   logic [7:0] mbase;
   logic       blocked;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         base    <= 8'hFF;
         idx     <= '0;
         dcnt    <= '0;
         wr_pend <= 1'b0;
         wr_idx  <= '0;
         wr_data <= '0;
         restart <= 1'b0;
      end else if (mcyc_en) begin
         // The write stage captures the byte read this M-cycle even when FF46 is rewritten.
         wr_pend <= (state == XFER);
         if (state == XFER) begin
            wr_idx  <= idx;
            wr_data <= src_data;
         end
         if (reg_wr) begin
            base    <= reg_wdata;
            idx     <= '0;
            dcnt    <= DLY_INIT;
            state   <= (START_DELAY == 0) ? XFER : DELAY;
            restart <= (state == XFER) || restart;
         end else begin
            case (state)
               DELAY: begin
                  dcnt <= dcnt - 2'd1;
                  if (dcnt == 2'd1) begin
                     state <= XFER;
                     idx   <= '0;
                  end
               end
               XFER: begin
                  idx <= idx + 8'd1;
                  if (idx == LAST_IDX) begin
                     state   <= IDLE;
                     restart <= 1'b0;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Pulse on the edge that retires the final OAM write of a transfer that was not restarted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done <= 1'b0;
      end else begin
         done <= mcyc_en && wr_pend && (state == IDLE);
      end
   end

   always_comb begin
      mbase      = (base >= 8'hE0) ? 8'(base - 8'h20) : base;
      src_rd     = (state == XFER);
      src_addr   = {mbase, idx};
      oam_wr     = wr_pend;
      oam_addr   = wr_idx;
      oam_wdata  = wr_data;
      reg_rdata  = base;
      dma_active = (state == XFER) || wr_pend || restart;
   end

`ifdef OAM_DMA_BUS_LOCK_EN
   always_comb begin
      blocked = !((cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE));
      cpu_gnt = !(dma_active && blocked);
   end
`else
   // Only OAM and the 8 KiB region currently being sourced conflict with the DMA.
   always_comb begin
      blocked = (cpu_addr[15:8] == 8'hFE) || (cpu_addr[15:13] == src_addr[15:13]);
      cpu_gnt = !(dma_active && blocked);
   end
`endif

endmodule
